// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, request/response records, fadd pipeline depth
// and a leading-zero counter used by the fadd normaliser.
package fpu_pkg;

  localparam logic FOP_ADD    = 1'b0;
  localparam logic FOP_SUB    = 1'b1;
  localparam int   FADD_LAT   = 1;
  localparam int   FADD_TAG_W = 5;

  typedef struct packed {
    logic                  op;
    logic [31:0]           x1;
    logic [31:0]           x2;
    logic [FADD_TAG_W-1:0] tag;
  } fadd_req_t;

  typedef struct packed {
    logic [31:0]           y;
    logic [FADD_TAG_W-1:0] tag;
  } fadd_rsp_t;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fadd.sv
// Two-stage IEEE-754 single adder, round-to-nearest-even: align -> register -> add/normalise/round.
// Denormal inputs and underflowing results are flushed to zero.
module fadd
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);
  logic [30:0] w_mag1, w_mag2;
  logic        w_swap, w_nan, w_inf1, w_inf2;
  logic [31:0] w_big, w_sml, w_spec_y;
  logic [23:0] w_m_big, w_m_sml;
  logic [7:0]  w_diff;
  logic [5:0]  w_shamt;
  logic [71:0] w_wide;

  always_comb begin
    w_mag1   = (x1[30:23] == 8'd0) ? 31'd0 : x1[30:0];
    w_mag2   = (x2[30:23] == 8'd0) ? 31'd0 : x2[30:0];
    w_swap   = (w_mag2 > w_mag1);
    w_big    = w_swap ? {x2[31], w_mag2} : {x1[31], w_mag1};
    w_sml    = w_swap ? {x1[31], w_mag1} : {x2[31], w_mag2};
    w_m_big  = {w_big[30:23] != 8'd0, w_big[22:0]};
    w_m_sml  = {w_sml[30:23] != 8'd0, w_sml[22:0]};
    w_diff   = w_big[30:23] - w_sml[30:23];
    // Any shift past 26 leaves only sticky bits, so clamping loses nothing.
    w_shamt  = (w_diff > 8'd48) ? 6'd48 : w_diff[5:0];
    w_wide   = {w_m_sml, 48'd0} >> w_shamt;
    w_inf1   = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
    w_inf2   = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
    w_nan    = ((x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0)) ||
               ((x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0)) ||
               (w_inf1 && w_inf2 && (x1[31] != x2[31]));
    w_spec_y = w_nan ? 32'h7FC0_0000 : (w_inf1 ? x1 : x2);
  end

  logic        r_sign, r_sub, r_sticky, r_special;
  logic [7:0]  r_exp;
  logic [23:0] r_m_big;
  logic [25:0] r_sml_al;
  logic [31:0] r_spec_y;

  always_ff @(posedge clk) begin
    r_sign    <= w_big[31];
    r_sub     <= w_big[31] ^ w_sml[31];
    r_exp     <= w_big[30:23];
    r_m_big   <= w_m_big;
    r_sml_al  <= w_wide[71:46];
    r_sticky  <= |w_wide[45:0];
    r_special <= (&x1[30:23]) | (&x2[30:23]);
    r_spec_y  <= w_spec_y;
  end

  logic [27:0] w_a, w_b, w_sum;
  logic [26:0] w_norm;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp;
  logic        w_up;
  logic [24:0] w_mant;
  logic [22:0] w_frac;

  always_comb begin
    w_a   = {1'b0, r_m_big, 3'b000};
    w_b   = {1'b0, r_sml_al, r_sticky};
    w_sum = r_sub ? (w_a - w_b) : (w_a + w_b);
    w_lz  = lzc27(w_sum[26:0]);
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, r_exp} + 10'd1;
    end else begin
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = {2'b00, r_exp} - {5'd0, w_lz};
    end
    w_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant = {1'b0, w_norm[26:3]} + {24'd0, w_up};
    w_frac = w_mant[22:0];
    if (w_mant[24]) begin
      w_exp  = w_exp + 10'd1;
      w_frac = w_mant[23:1];
    end
    if (r_special)                       y = r_spec_y;
    else if (w_sum == 28'd0)             y = {r_sub ? 1'b0 : r_sign, 31'd0};
    else if (w_exp[9] || w_exp == 10'd0) y = {r_sign, 31'd0};
    else if (w_exp >= 10'd255)           y = {r_sign, 8'hFF, 23'd0};
    else                                 y = {r_sign, w_exp[7:0], w_frac};
  end

endmodule

// File: rtl/fpu_result_fifo.sv
// Circular result buffer; o_data reads the head entry and is zero while empty.
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // The issue-side credit check makes both of these unreachable.
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst || i_clr) i_push |-> (r_count < FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || i_clr) i_pop |-> (r_count != '0));

endmodule

// File: rtl/fadd_issue.sv
// Valid/ready front-end for the 2-stage fadd: credit-based issue, tag pipe, result FIFO.
// Optional flush port enabled by defining FADD_ISSUE_FLUSH_EN.
module fadd_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef FADD_ISSUE_FLUSH_EN
  ,
  input  logic             flush
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 32 + TAG_W;

  // Handshakes: a beat moves on a cycle where valid & ready are both high; the sender
  // holds its payload stable until then, and ready never depends on the same-cycle valid.
  logic             w_flush;
  logic             w_accept;
  logic             w_pop;
  logic [31:0]      w_x1, w_x2, w_y;
  logic [CW-1:0]    w_count, w_used;
  logic             w_empty;
  logic [W-1:0]     w_head;
  logic             r_vld_p1;
  logic [TAG_W-1:0] r_tag_p1;

`ifdef FADD_ISSUE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Credits count the in-flight op too; a pop only frees a credit on the next cycle.
  assign w_used   = w_count + CW'(r_vld_p1);
  assign in_ready = !rst && !w_flush && (w_used < CW'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_x1     = w_accept ? in_x1 : 32'd0;
  assign w_x2     = !w_accept ? 32'd0 :
                    (in_op == FOP_SUB) ? {~in_x2[31], in_x2[30:0]} : in_x2;

  fadd u_fadd (
    .clk (clk),
    .x1  (w_x1),
    .x2  (w_x2),
    .y   (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_vld_p1 <= 1'b0;
      r_tag_p1 <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      r_tag_p1 <= in_tag;
    end
  end

  assign w_pop = out_valid && out_ready;

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_push  (r_vld_p1),
    .i_data  ({w_y, r_tag_p1}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign out_valid        = !w_empty;
  assign {out_y, out_tag} = w_head;

endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: operands are scaled integers n*2^e so every sum is exact and
// the expected result follows from integer arithmetic; a queue models credits and latency.
module tb_fadd_issue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int W     = 32 + TAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_op = 1'b0;
  logic [31:0]      in_x1 = '0;
  logic [31:0]      in_x2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             flush = 1'b0;

  fadd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
`ifdef FADD_ISSUE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- counters / scoreboard ----------------
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [W-1:0] exp_q[$];
  int          cyc_q[$];
  int          pop_tags[$];
  logic [31:0] cur_exp = '0;
  logic        last_acc = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic        m_ready, m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // value n * 2^e as single precision; exact for |n| < 2^24
  function automatic logic [31:0] to_fp(input int n, input int e);
    int          m;
    int          p;
    logic [31:0] f;
    if (n == 0) return 32'h0;
    m = (n < 0) ? -n : n;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    f = 32'(m) << (23 - p);
    return {n < 0, 8'(127 + p + e), f[22:0]};
  endfunction

  // Reference: outstanding ops in acceptance order; ready when fewer than DEPTH are
  // outstanding at cycle start; each result is visible two cycles after its accept.
  always @(negedge clk) begin
    m_ready = !rst && !flush && (exp_q.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    last_acc = m_ready && in_valid;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
    end else begin
      m_valid = (exp_q.size() > 0) && (cyc_q[0] + 2 <= cyc);
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_y_tag", 64'({out_y, out_tag}), 64'(exp_q[0]));
        if (out_ready) begin
          pop_tags.push_back(int'(out_tag));
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete();
        cyc_q.delete();
      end
      if (last_acc) begin
        exp_q.push_back({cur_exp, in_tag});
        cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic op, input logic [31:0] x1, input logic [31:0] x2,
                          input logic [TAG_W-1:0] tag, input logic [31:0] expy);
    int waited;
    in_valid = 1'b1; in_op = op; in_x1 = x1; in_x2 = x2; in_tag = tag; cur_exp = expy;
    waited = 0;
    do begin
      @(posedge clk);
      waited++;
    end while (!last_acc && waited < 64);
    if (!last_acc) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_int(input logic op, input int n1, input int n2, input int e,
                          input logic [TAG_W-1:0] tag);
    send_raw(op, to_fp(n1, e), to_fp(n2, e), tag, to_fp(op ? n1 - n2 : n1 + n2, e));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n_acc, c0, n1, n2, e;
    logic op;

    chk("model_1p0", 64'(to_fp(1, 0)), 64'h3F80_0000);
    chk("model_3p0", 64'(to_fp(3, 0)), 64'h4040_0000);
    chk("model_m1p0", 64'(to_fp(-1, 0)), 64'hBF80_0000);
    chk("model_0p75", 64'(to_fp(3, -2)), 64'h3F40_0000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // add 1.0 + 2.0, then check latency 2 with literal values
    out_ready = 1'b1;
    send_raw(FOP_ADD, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000);
    @(negedge clk);
    chk("t1_valid_t1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_t2", 64'(out_valid), 64'd1);
    chk("t1_y", 64'(out_y), 64'h4040_0000);
    chk("t1_tag", 64'(out_tag), 64'd3);
    @(posedge clk); #1;

    // subtraction cases
    send_raw(FOP_SUB, 32'h4040_0000, 32'h3F80_0000, 5'd4, 32'h4000_0000);
    send_raw(FOP_SUB, 32'h3F80_0000, 32'h3F80_0000, 5'd5, 32'h0000_0000);
    idle(4);

    // backpressure: in_valid held, exactly DEPTH accepts
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = FOP_ADD; in_tag = TAG_W'(n_acc);
      in_x1 = to_fp(n_acc + 1, 0); in_x2 = to_fp(1, 0); cur_exp = to_fp(n_acc + 2, 0);
      @(posedge clk);
      if (last_acc) n_acc++;
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(n_acc), 64'd4);
    pop_tags.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pop_cycle", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    idle(6);
    chk("bp_drain_n", 64'(pop_tags.size()), 64'd4);
    for (int i = 0; i < pop_tags.size() && i < 4; i++) chk("bp_drain_tag", 64'(pop_tags[i]), 64'(i));

    // streaming: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_int(FOP_ADD, i, 2 * i + 1, -1, TAG_W'(i));
    chk("stream_cycles", 64'(cyc - c0), 64'd8);
    idle(5);

    // reset with three ops outstanding
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_int(FOP_SUB, 10 + i, 3, 0, TAG_W'(20 + i));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_int(FOP_ADD, 7, 9, 2, 5'd9);
    idle(5);

`ifdef FADD_ISSUE_FLUSH_EN
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_int(FOP_ADD, i, 5, 0, TAG_W'(i));
    flush = 1'b1;
    in_valid = 1'b1; in_op = FOP_ADD; in_x1 = to_fp(1, 0); in_x2 = to_fp(1, 0);
    in_tag = 5'd30; cur_exp = to_fp(2, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
`endif

    // randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      op = 1'($urandom_range(0, 1));
      e  = int'($urandom_range(0, 16)) - 8;
      n1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1 << 20)) : int'($urandom_range(0, 16));
      if ($urandom_range(0, 1) != 0) n1 = -n1;
      if ($urandom_range(0, 4) == 0) n2 = n1;
      else begin
        n2 = int'($urandom_range(0, 1 << 20));
        if ($urandom_range(0, 1) != 0) n2 = -n2;
      end
      send_int(op, n1, n2, e, TAG_W'($urandom_range(0, 31)));
    end
    rnd_rdy = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(12);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
